// File: rtl/reg_access_seq_pkg.sv
// Shared definitions for the register-access sequencer and the register file it drives.
// Holds the FSM state type, the rf_r_or_w encoding and the default widths.
package reg_access_seq_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 4;

  localparam logic RF_READ  = 1'b0;
  localparam logic RF_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    OUT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/reg_access_seq.sv
// Owns the single register-file port: fetches one or two operands per instruction
// and slots write-backs onto the same port, which take priority over new fetches.
module reg_access_seq
  import reg_access_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              use_rs2_i,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [WIDTH-1:0]  wb_data_i,
  output logic              rf_en_o,
  output logic              rf_r_or_w_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [WIDTH-1:0]  rf_wdata_o,
  input  logic [WIDTH-1:0]  rf_rdata_i,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [WIDTH-1:0]  op_a_o,
  output logic [WIDTH-1:0]  op_b_o,
  output logic [ADDR_W-1:0] op_rd_o
);

  seq_state_t        state_q;
  logic [ADDR_W-1:0] rs2_q;
  logic              use_rs2_q;
  logic              rf_en_q;
  logic              rf_r_or_w_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [WIDTH-1:0]  rf_wdata_q;
  logic              op_valid_q;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic [ADDR_W-1:0] op_rd_q;
  logic              wb_fire;
  logic              instr_fire;

  // Write-backs are only taken in states where the port is not busy with a fetch.
  assign wb_ready_o    = (state_q == IDLE) || (state_q == OUT);
  assign instr_ready_o = (state_q == IDLE) && !wb_valid_i;
  assign wb_fire       = wb_valid_i && wb_ready_o;
  assign instr_fire    = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rs2_q       <= '0;
      use_rs2_q   <= 1'b0;
      rf_en_q     <= 1'b0;
      rf_r_or_w_q <= RF_READ;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_rd_q     <= '0;
    end else begin
      // The port idles unless an access is issued below this cycle.
      rf_en_q <= 1'b0;

      if (wb_fire) begin
        rf_en_q     <= 1'b1;
        rf_r_or_w_q <= RF_WRITE;
        rf_addr_q   <= wb_addr_i;
        rf_wdata_q  <= wb_data_i;
      end

      case (state_q)
        IDLE: begin
          if (instr_fire) begin
            rs2_q       <= rs2_i;
            use_rs2_q   <= use_rs2_i;
            op_rd_q     <= rd_i;
            rf_en_q     <= 1'b1;
            rf_r_or_w_q <= RF_READ;
            rf_addr_q   <= rs1_i;
            state_q     <= RD_A;
          end
        end
        RD_A: begin
          op_a_q <= rf_rdata_i;
          if (use_rs2_q) begin
            rf_en_q     <= 1'b1;
            rf_r_or_w_q <= RF_READ;
            rf_addr_q   <= rs2_q;
            state_q     <= RD_B;
          end else begin
            op_b_q     <= '0;
            op_valid_q <= 1'b1;
            state_q    <= OUT;
          end
        end
        RD_B: begin
          op_b_q     <= rf_rdata_i;
          op_valid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          if (op_ready_i) begin
            op_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_en_o     = rf_en_q;
  assign rf_r_or_w_o = rf_r_or_w_q;
  assign rf_addr_o   = rf_addr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign op_valid_o  = op_valid_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign op_rd_o     = op_rd_q;

endmodule

// File: tb/tb_reg_access_seq.sv
// Directed bench for reg_access_seq paired with a falling-edge register file model
// that drives high-Z on its read data whenever no read is in progress.
module tb_reg_access_seq;

  logic        clk;
  logic        rst;
  logic        instrValid;
  logic        instrReady;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  rd;
  logic        useRs2;
  logic        wbValid;
  logic        wbReady;
  logic [3:0]  wbAddr;
  logic [15:0] wbData;
  logic        rfEn;
  logic        rfROrW;
  logic [3:0]  rfAddr;
  logic [15:0] rfWdata;
  logic [15:0] rfRdata;
  logic        opValid;
  logic        opReady;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [3:0]  opRd;

  logic [15:0] rfMem [16];

  int compareCount = 0;
  int mismatchCount = 0;

  reg_access_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (instrValid),
    .instr_ready_o (instrReady),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rd_i          (rd),
    .use_rs2_i     (useRs2),
    .wb_valid_i    (wbValid),
    .wb_ready_o    (wbReady),
    .wb_addr_i     (wbAddr),
    .wb_data_i     (wbData),
    .rf_en_o       (rfEn),
    .rf_r_or_w_o   (rfROrW),
    .rf_addr_o     (rfAddr),
    .rf_wdata_o    (rfWdata),
    .rf_rdata_i    (rfRdata),
    .op_valid_o    (opValid),
    .op_ready_i    (opReady),
    .op_a_o        (opA),
    .op_b_o        (opB),
    .op_rd_o       (opRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: acts on the falling edge, read data floats unless a read was issued.
  always @(negedge clk) begin
    if (rfEn && rfROrW) begin
      rfMem[rfAddr] <= rfWdata;
      rfRdata       <= 'z;
    end else if (rfEn) begin
      rfRdata <= rfMem[rfAddr];
    end else begin
      rfRdata <= 'z;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] dst, input logic u2, input logic wv,
                               input logic [3:0] wa, input logic [15:0] wd, input logic ordy);
    instrValid = iv;
    rs1        = a1;
    rs2        = a2;
    rd         = dst;
    useRs2     = u2;
    wbValid    = wv;
    wbAddr     = wa;
    wbData     = wd;
    opReady    = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_rf_en", rfEn, 0);
    checkOutput("rst_rf_r_or_w", rfROrW, 0);
    checkOutput("rst_rf_addr", rfAddr, 0);
    checkOutput("rst_rf_wdata", rfWdata, 0);
    checkOutput("rst_op_valid", opValid, 0);
    checkOutput("rst_op_a", opA, 0);
    checkOutput("rst_op_b", opB, 0);
    checkOutput("rst_op_rd", opRd, 0);
    checkOutput("rst_instr_ready", instrReady, 1);
    checkOutput("rst_wb_ready", wbReady, 1);

    // Single-source instruction reading a freshly written register.
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd3, 16'h1234, 0);
    checkOutput("t1_wb_ready", wbReady, 1);
    tick();
    checkOutput("t1_wr_en", rfEn, 1);
    checkOutput("t1_wr_dir", rfROrW, 1);
    checkOutput("t1_wr_addr", rfAddr, 3);
    checkOutput("t1_wr_data", rfWdata, 16'h1234);
    applyStimulus(1, 4'd3, 0, 4'd5, 0, 0, 0, 16'h0, 0);
    checkOutput("t1_instr_ready", instrReady, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    checkOutput("t1_rd_en", rfEn, 1);
    checkOutput("t1_rd_dir", rfROrW, 0);
    checkOutput("t1_rd_addr", rfAddr, 3);
    checkOutput("t1_early_valid", opValid, 0);
    tick();
    checkOutput("t1_op_valid", opValid, 1);
    checkOutput("t1_op_a", opA, 16'h1234);
    checkOutput("t1_op_b", opB, 0);
    checkOutput("t1_op_rd", opRd, 5);
    checkOutput("t1_rf_idle", rfEn, 0);
    checkOutput("t1_no_accept_in_out", instrReady, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    tick();
    checkOutput("t1_valid_clear", opValid, 0);
    checkOutput("t1_back_idle", instrReady, 1);

    // Two-source instruction with back-to-back preloads.
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd1, 16'h00AA, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd2, 16'h5500, 0);
    checkOutput("t2_wb_b2b_ready", wbReady, 1);
    tick();
    checkOutput("t2_wb2_addr", rfAddr, 2);
    applyStimulus(1, 4'd1, 4'd2, 4'd6, 1, 0, 0, 16'h0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    checkOutput("t2_rd1_addr", rfAddr, 1);
    tick();
    checkOutput("t2_rd2_en", rfEn, 1);
    checkOutput("t2_rd2_dir", rfROrW, 0);
    checkOutput("t2_rd2_addr", rfAddr, 2);
    checkOutput("t2_mid_valid", opValid, 0);
    checkOutput("t2_op_a_early", opA, 16'h00AA);
    tick();
    checkOutput("t2_op_valid", opValid, 1);
    checkOutput("t2_op_a", opA, 16'h00AA);
    checkOutput("t2_op_b", opB, 16'h5500);
    checkOutput("t2_op_rd", opRd, 6);
    checkOutput("t2_rf_idle", rfEn, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    tick();
    checkOutput("t2_valid_clear", opValid, 0);
    checkOutput("t2_rf_idle_after", rfEn, 0);

    // Write-back and instruction arriving together: the write goes first.
    applyStimulus(1, 4'd4, 0, 4'd8, 0, 1, 4'd4, 16'hBEEF, 0);
    checkOutput("t3_instr_blocked", instrReady, 0);
    checkOutput("t3_wb_ready", wbReady, 1);
    tick();
    checkOutput("t3_wr_dir", rfROrW, 1);
    checkOutput("t3_wr_addr", rfAddr, 4);
    applyStimulus(1, 4'd4, 0, 4'd8, 0, 0, 0, 16'h0, 0);
    checkOutput("t3_instr_ready", instrReady, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    checkOutput("t3_rd_dir", rfROrW, 0);
    tick();
    checkOutput("t3_op_valid", opValid, 1);
    checkOutput("t3_op_a", opA, 16'hBEEF);
    checkOutput("t3_op_rd", opRd, 8);

    // Stall in OUT while write-backs to r7 stream through every cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 4'd1, 0, 0, 0, 1, 4'd7, 16'(16'h7000 + i), 0);
      checkOutput("t4_wb_ready", wbReady, 1);
      checkOutput("t4_instr_ready", instrReady, 0);
      tick();
      checkOutput("t4_wr_en", rfEn, 1);
      checkOutput("t4_wr_dir", rfROrW, 1);
      checkOutput("t4_wr_addr", rfAddr, 7);
      checkOutput("t4_wr_data", rfWdata, 32'(16'h7000 + i));
      checkOutput("t4_hold_valid", opValid, 1);
      checkOutput("t4_hold_a", opA, 16'hBEEF);
      checkOutput("t4_hold_b", opB, 0);
      checkOutput("t4_hold_rd", opRd, 8);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd7, 16'h7777, 1);
    tick();
    checkOutput("t4_release_valid", opValid, 0);
    checkOutput("t4_release_wr_en", rfEn, 1);
    checkOutput("t4_release_wr_data", rfWdata, 16'h7777);
    checkOutput("t4_idle_wb_blocks", instrReady, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    checkOutput("t4_idle_ready", instrReady, 1);

    // Preload r9, then abandon a two-source fetch with reset during RD_B.
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd9, 16'h0F0F, 0);
    tick();
    applyStimulus(1, 4'd1, 4'd2, 4'd3, 1, 0, 0, 16'h0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    tick();
    checkOutput("t5_in_rd_b", rfAddr, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_rf_en", rfEn, 0);
    checkOutput("t5_rst_valid", opValid, 0);
    checkOutput("t5_rst_op_a", opA, 0);
    checkOutput("t5_rst_idle", instrReady, 1);
    tick();
    checkOutput("t5_nothing_presented", opValid, 0);
    applyStimulus(1, 4'd7, 0, 4'd2, 0, 0, 0, 16'h0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    tick();
    checkOutput("t5_after_valid", opValid, 1);
    checkOutput("t5_after_op_a", opA, 16'h7777);
    checkOutput("t5_after_op_rd", opRd, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    tick();

    // Same register as both sources.
    applyStimulus(1, 4'd9, 4'd9, 4'd10, 1, 0, 0, 16'h0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 0);
    tick();
    checkOutput("t6_second_read_addr", rfAddr, 9);
    checkOutput("t6_second_read_en", rfEn, 1);
    tick();
    checkOutput("t6_op_valid", opValid, 1);
    checkOutput("t6_op_a", opA, 16'h0F0F);
    checkOutput("t6_op_b", opB, 16'h0F0F);
    checkOutput("t6_op_rd", opRd, 10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    tick();
    checkOutput("t6_valid_clear", opValid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
